// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry, line levels.
package uart_pkg;

  localparam int unsigned UART_DATA_SIZE = 8;
  localparam int unsigned UART_SAMPLE    = 16;
  localparam int unsigned UART_TICK_W    = $clog2(UART_SAMPLE);
  localparam int unsigned UART_BIT_W     = $clog2(UART_DATA_SIZE + 1);

  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus falling-edge detect qualified by sample_clk.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sample_clk,
  input  logic serial_data_in,
  output logic rx_s,
  output logic fall_edge
);

  logic meta;
  logic rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta    <= UART_IDLE_LEVEL;
      rx_s    <= UART_IDLE_LEVEL;
      rx_prev <= UART_IDLE_LEVEL;
    end else begin
      meta <= serial_data_in;
      rx_s <= meta;
      if (sample_clk) rx_prev <= rx_s;
    end
  end

  // Edge is only meaningful on a tick, where rx_prev holds the previous tick's level
  assign fall_edge = sample_clk & rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start/stop validation, one byte per frame with a 1-cycle valid pulse.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_SIZE = UART_DATA_SIZE,
  parameter int unsigned SAMPLE    = UART_SAMPLE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_clk,
  input  logic                 serial_data_in,
  output logic [DATA_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int unsigned TICK_W = $clog2(SAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_SIZE + 1);

  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(SAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  logic                 rx_s;
  logic                 fall_edge;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_SIZE-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  uart_rx_sync u_sync (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_clk     (sample_clk),
    .serial_data_in (serial_data_in),
    .rx_s           (rx_s),
    .fall_edge      (fall_edge)
  );

  // Receive FSM: state and counters move on sample_clk, pulse outputs clear every clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RX_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      if (sample_clk) begin
        case (state)
          RX_IDLE: begin
            if (fall_edge) begin
              state    <= RX_START;
              tick_cnt <= '0;
              rx_busy  <= 1'b1;
            end
          end
          RX_START: begin
            if (tick_cnt == TICK_HALF) begin
              tick_cnt <= '0;
              if (!rx_s) begin
                state   <= RX_DATA;
                bit_cnt <= '0;
              end else begin
                state   <= RX_IDLE;
                rx_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          RX_DATA: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_s, shift_reg[DATA_SIZE-1:1]};
              bit_cnt   <= bit_cnt + BIT_W'(1);
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= RX_PARITY;
`else
                state <= RX_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          RX_PARITY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              par_bad  <= (^shift_reg) ^ rx_s;
              state    <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
`endif
          RX_STOP: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= RX_IDLE;
              rx_busy  <= 1'b0;
              if (!rx_s) begin
                frame_error <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if (par_bad) begin
                parity_error <= 1'b1;
`endif
              end else begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
          default: begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: directed frames queue expected events, a monitor pops and compares.
module tb_uart_receiver;

  localparam int unsigned DW       = 8;
  localparam int unsigned SMP      = 16;
  localparam int unsigned TICK_CYC = 4;
  localparam int unsigned BIT_CYC  = SMP * TICK_CYC;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned BUSY_CYC = (SMP / 2 + SMP * (DW + PBITS) + SMP) * TICK_CYC;

  localparam int EV_VALID = 0;
  localparam int EV_FRAME = 1;
  localparam int EV_PAR   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_clk = 1'b0;
  logic          serial_data_in = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_busy;
  logic          frame_error;
  logic          parity_error;

  typedef struct {
    int            kind;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_run = 0;
  int   last_busy = 0;
  int   div = 0;

  uart_receiver #(.DATA_SIZE(DW), .SAMPLE(SMP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sample_clk     (sample_clk),
    .serial_data_in (serial_data_in),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_busy        (rx_busy),
    .frame_error    (frame_error),
    .parity_error   (parity_error)
  );

  always #5 clk = ~clk;

  // 1-in-TICK_CYC enable, changed on the falling edge so it is stable at posedge
  always @(negedge clk) begin
    div        <= (div == TICK_CYC - 1) ? 0 : div + 1;
    sample_clk <= (div == TICK_CYC - 1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid || frame_error || parity_error) begin
        int   kind;
        exp_t e;
        kind = rx_valid ? EV_VALID : (frame_error ? EV_FRAME : EV_PAR);
        check("pulse_exclusive", 32'(rx_valid) + 32'(frame_error) + 32'(parity_error), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d data %0h expected none at %0t", kind, rx_data, $time);
        end else begin
          e = sb.pop_front();
          check("event_kind", 32'(kind), 32'(e.kind));
          check("event_rx_data", 32'(rx_data), 32'(e.data));
        end
      end
      if (rx_busy) busy_run++;
      else if (busy_run != 0) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
    end
  end

  task automatic line_bits(input logic b, input int unsigned nbits);
    serial_data_in = b;
    repeat (nbits * BIT_CYC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input logic par_flip);
    line_bits(1'b0, 1);
    for (int i = 0; i < int'(DW); i++) line_bits(d[i], 1);
`ifdef UART_RX_PARITY_EN
    line_bits((^d) ^ par_flip, 1);
`else
    if (par_flip) line_bits(1'b1, 0);
`endif
    line_bits(stop_bit, 1);
  endtask

  task automatic check_quiet(input string name, input logic [DW-1:0] data);
    check({name, "_pending"}, 32'(sb.size()), 32'd0);
    check({name, "_busy"}, 32'(rx_busy), 32'd0);
    check({name, "_rx_data"}, 32'(rx_data), 32'(data));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    check("reset_parity_error", 32'(parity_error), 32'd0);
    reset_n = 1'b1;
    line_bits(1'b1, 2);

    // Single 8N1 frame
    push(EV_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    line_bits(1'b1, 2);
    check("a5_busy_cycles", 32'(last_busy), 32'(BUSY_CYC));
    check_quiet("a5", 8'hA5);

    // Short low glitch must not start a frame
    line_bits(1'b0, 0);
    repeat (4 * TICK_CYC) @(negedge clk);
    line_bits(1'b1, 2);
    check_quiet("glitch", 8'hA5);

    // Stop bit low -> frame error, data held
    push(EV_FRAME, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    line_bits(1'b1, 2);
    check_quiet("bad_stop", 8'hA5);

    // Break: one frame error only, then a fresh frame after release
    push(EV_FRAME, 8'hA5);
    push(EV_VALID, 8'h01);
    line_bits(1'b0, 30);
    line_bits(1'b1, 2);
    send_frame(8'h01, 1'b1, 1'b0);
    line_bits(1'b1, 2);
    check_quiet("break", 8'h01);

    // Back-to-back frames with no idle between them
    push(EV_VALID, 8'h00);
    push(EV_VALID, 8'hFF);
    push(EV_VALID, 8'h55);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    line_bits(1'b1, 2);
    check_quiet("b2b", 8'h55);

`ifdef UART_RX_PARITY_EN
    push(EV_VALID, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    line_bits(1'b1, 2);
    check_quiet("par_ok", 8'h07);
    push(EV_PAR, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    line_bits(1'b1, 2);
    check_quiet("par_bad", 8'h07);
`endif

    // Reset mid-frame discards the partial byte
    line_bits(1'b0, 3);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(rx_busy), 32'd0);
    check("midreset_rx_data", 32'(rx_data), 32'd0);
    line_bits(1'b1, 1);
    reset_n = 1'b1;
    line_bits(1'b1, 2);
    check_quiet("midreset", 8'h00);
    push(EV_VALID, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    line_bits(1'b1, 2);
    check_quiet("after_reset", 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver; the receive end of the link driven by uart_transmitter.
- Oversamples serial_data_in using the 16x sample_clk enable from uart_generator_clock.
- Validates start and stop bits and emits one byte per frame with a 1-cycle valid pulse.
- Sits between the board RX pin and a receive uart_fifo; rx_valid drives the fifo write and rx_data drives its data_in.

Parameters:
- DATA_SIZE, 8: data bits per frame, LSB first.
- SAMPLE, 16: sample ticks per bit period; must be even and at least 4.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sample_clk  input  1  1-cycle enable at SAMPLE x baud rate (from uart_generator_clock).
- serial_data_in  input  1  asynchronous serial line; idle high.
- rx_data  output  DATA_SIZE  last correctly received byte.
- rx_valid  output  1  1-cycle pulse; rx_data is new this cycle.
- rx_busy  output  1  high while a frame is being received (state other than IDLE).
- frame_error  output  1  1-cycle pulse when a stop bit samples low.
- parity_error  output  1  1-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: rx_data=0, rx_valid=0, rx_busy=0, frame_error=0, parity_error=0.
  - Internal: state=IDLE, synchronizer flops=1, tick_cnt=0, bit_cnt=0.
- Reset mid-frame aborts the frame with no pulses; the partial byte is discarded.
- Input conditioning:
  - 2-flop synchronizer on serial_data_in, giving rx_s.
  - rx_prev holds rx_s from the previous sample_clk tick.
  - Falling edge = rx_prev=1 and rx_s=0, evaluated only on sample_clk.
- All counters and state advance only on cycles where sample_clk=1; outputs update on clk.
- State IDLE: on falling edge -> START, tick_cnt=0. A line held low never starts a frame; a high-to-low transition is required.
- State START: tick_cnt increments each tick.
  - At tick_cnt=SAMPLE/2-1, if rx_s=0 -> DATA with tick_cnt=0, bit_cnt=0.
  - If rx_s=1 at that point (glitch) -> IDLE, no pulse.
- State DATA: at tick_cnt=SAMPLE-1 (bit centre):
  - Shift rx_s into the MSB of shift_reg with a right shift, so the first-received bit ends as bit 0.
  - bit_cnt++, tick_cnt=0.
  - After bit_cnt reaches DATA_SIZE -> PARITY (macro on) or STOP.
- State PARITY (macro only): at tick_cnt=SAMPLE-1, capture the parity bit -> STOP.
- State STOP: at tick_cnt=SAMPLE-1:
  - If rx_s=1: rx_data<=shift_reg and rx_valid pulses, unless a parity mismatch was captured, in which case parity_error pulses instead and rx_data is held.
  - If rx_s=0: frame_error pulses and rx_data is held.
  - Return to IDLE in all cases.
- Latency: rx_valid asserts on the clk edge following the stop-centre sample_clk. That is 1.5 + DATA_SIZE bit periods after the start edge, plus 2 synchronizer cycles.
- rx_valid, frame_error and parity_error are mutually exclusive and each lasts exactly 1 clk cycle.
- Break (line low for longer than a frame):
  - Exactly one frame_error, then IDLE.
  - No new frame starts until the line returns high and falls again.
- Back-to-back frames: a falling edge on the tick immediately after STOP completes must be accepted (no dead time beyond 1 tick).
- sample_clk held low freezes the FSM; this is legal and must cause no spurious pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after the data bits.
  - Parity is the XOR of the data bits and the parity bit; a nonzero result is a mismatch.
  - A mismatch pulses parity_error at stop-bit time and rx_valid is suppressed.
  - Frame length is 1 + DATA_SIZE + 1 + 1 bits.
- Undefined: no PARITY state; parity_error is constant 0; frame length is 1 + DATA_SIZE + 1 bits.

Decomposition:
- Package uart_pkg, shared with the transmitter:
  - rx state enum (IDLE, START, DATA, PARITY, STOP).
  - Localparams for the tick counter width ($clog2(SAMPLE)) and bit counter width ($clog2(DATA_SIZE+1)).
  - Idle line level constant (1).
- One sub-module, uart_rx_sync:
  - 2-flop synchronizer plus tick-qualified edge detect.
  - Outputs rx_s and fall_edge.
  - Async active-low reset to 1.

Test Plan:
- Byte 0xA5, SAMPLE=16, 8N1 -> exactly one rx_valid with rx_data=0xA5; rx_busy high for 9.5 bit periods; no error pulses.
- Low glitch of 4 ticks on an idle line -> return to IDLE; rx_valid, frame_error and rx_busy end low; rx_data unchanged.
- 0x3C sent with stop bit forced 0 -> one frame_error pulse, no rx_valid, rx_data keeps the previous 0x00 or last byte.
- Line held low for 3 frame times, then released, then 0x01 sent -> exactly one frame_error, then rx_valid with 0x01.
- Back-to-back frames 0x00, 0xFF, 0x55 with zero idle between them -> three rx_valid pulses in order, no errors.
- UART_RX_PARITY_EN defined: 0x07 with parity bit 1 -> rx_valid with 0x07. Same byte with parity bit 0 -> parity_error pulse, no rx_valid.
